// File: rtl/equiv_sweep_if.sv
// Handshake and result bundle between the equivalence sweep controller and
// its surroundings (lab top level plus the two combinational circuits).
interface equiv_sweep_if #(
  parameter int N_IN = 4
);
  localparam int NV = 1 << N_IN;

  logic              start;
  logic              abort;
  logic              out_ref;
  logic              out_dut;
  logic [N_IN-1:0]   vec;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic              pass;
  logic [N_IN:0]     mismatch_count;
  logic [N_IN-1:0]   first_fail;
  logic              first_fail_valid;
  logic [NV-1:0]     table_ref;
  logic [NV-1:0]     table_dut;

  // Controller side: drives the vector bus and all results.
  modport master (
    input  start, abort, out_ref, out_dut,
    output vec, busy, done, result_valid, pass, mismatch_count,
           first_fail, first_fail_valid, table_ref, table_dut
  );

  // Environment side: issues commands, returns circuit outputs, reads results.
  modport slave (
    output start, abort, out_ref, out_dut,
    input  vec, busy, done, result_valid, pass, mismatch_count,
           first_fail, first_fail_valid, table_ref, table_dut
  );
endinterface

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep of two N_IN-input combinational circuits.
// Vectors are applied in ascending order, each held SETTLE+1 cycles, and both
// outputs are captured into truth tables while mismatches are counted.
module equiv_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  equiv_sweep_if.master sweep
);
  localparam int              NV         = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC   = '1;
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // With no settle time a new vector is sampled on its very first cycle.
  localparam state_t ENTRY_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t          r_state;
  logic [3:0]      r_settle;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_result_valid;
  logic            r_pass;
  logic [N_IN:0]   r_mis_cnt;
  logic [N_IN-1:0] r_first_fail;
  logic            r_first_fail_valid;
  logic [NV-1:0]   r_table_ref;
  logic [NV-1:0]   r_table_dut;

  logic            w_mis;
  logic [N_IN:0]   w_mis_cnt_next;

  assign w_mis          = sweep.out_ref ^ sweep.out_dut;
  assign w_mis_cnt_next = r_mis_cnt + {{N_IN{1'b0}}, w_mis};

  // Sweep sequencer: state, vector bus, truth tables and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_settle           <= '0;
      r_vec              <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_result_valid     <= 1'b0;
      r_pass             <= 1'b0;
      r_mis_cnt          <= '0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
      r_table_ref        <= '0;
      r_table_dut        <= '0;
    end else if (r_state != S_IDLE && sweep.abort) begin
      // Abandon the sweep; partial tables and count stay visible but invalid,
      // and the sample of this cycle is dropped.
      r_state        <= S_IDLE;
      r_vec          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sweep.start && !sweep.abort) begin
            r_state            <= ENTRY_STATE;
            r_settle           <= SETTLE_CNT;
            r_vec              <= '0;
            r_busy             <= 1'b1;
            r_result_valid     <= 1'b0;
            r_pass             <= 1'b0;
            r_mis_cnt          <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_table_ref        <= '0;
            r_table_dut        <= '0;
          end
        end
        S_SETTLE: begin
          r_settle <= r_settle - 4'd1;
          if (r_settle <= 4'd1) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_table_ref[r_vec] <= sweep.out_ref;
          r_table_dut[r_vec] <= sweep.out_dut;
          r_mis_cnt          <= w_mis_cnt_next;
          // Ascending order makes the first recorded mismatch the lowest one.
          if (w_mis && !r_first_fail_valid) begin
            r_first_fail       <= r_vec;
            r_first_fail_valid <= 1'b1;
          end
          if (r_vec == LAST_VEC) begin
            r_state        <= S_DONE;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
            r_result_valid <= 1'b1;
            r_pass         <= (w_mis_cnt_next == '0);
          end else begin
            r_state  <= ENTRY_STATE;
            r_settle <= SETTLE_CNT;
            r_vec    <= r_vec + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_vec   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sweep.vec              = r_vec;
  assign sweep.busy             = r_busy;
  assign sweep.done             = r_done;
  assign sweep.result_valid     = r_result_valid;
  assign sweep.pass             = r_pass;
  assign sweep.mismatch_count   = r_mis_cnt;
  assign sweep.first_fail       = r_first_fail;
  assign sweep.first_fail_valid = r_first_fail_valid;
  assign sweep.table_ref        = r_table_ref;
  assign sweep.table_dut        = r_table_dut;
endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Bench for equiv_sweep_ctrl: two instances (SETTLE=0 and SETTLE=1) share the
// command inputs; circuits are modelled as 16-entry truth tables.
module tb_equiv_sweep_ctrl;
  localparam logic [15:0] F_TT = 16'h8585;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] tt_ref;
  logic [15:0] tt_dut;

  equiv_sweep_if #(.N_IN(4)) s0 ();
  equiv_sweep_if #(.N_IN(4)) s1 ();

  assign s0.start   = start;
  assign s0.abort   = abort;
  assign s0.out_ref = tt_ref[s0.vec];
  assign s0.out_dut = tt_dut[s0.vec];
  assign s1.start   = start;
  assign s1.abort   = abort;
  assign s1.out_ref = tt_ref[s1.vec];
  assign s1.out_dut = tt_dut[s1.vec];

  equiv_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u_dut0 (.clk(clk), .reset(reset), .sweep(s0.master));
  equiv_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .reset(reset), .sweep(s1.master));

  logic [3:0]  a_vec [2];
  logic        a_busy[2], a_done[2], a_rv[2], a_pass[2], a_ffv[2];
  logic [4:0]  a_cnt [2];
  logic [3:0]  a_ff  [2];
  logic [15:0] a_tref[2], a_tdut[2];

  assign a_vec[0] = s0.vec;              assign a_vec[1] = s1.vec;
  assign a_busy[0] = s0.busy;            assign a_busy[1] = s1.busy;
  assign a_done[0] = s0.done;            assign a_done[1] = s1.done;
  assign a_rv[0] = s0.result_valid;      assign a_rv[1] = s1.result_valid;
  assign a_pass[0] = s0.pass;            assign a_pass[1] = s1.pass;
  assign a_ffv[0] = s0.first_fail_valid; assign a_ffv[1] = s1.first_fail_valid;
  assign a_cnt[0] = s0.mismatch_count;   assign a_cnt[1] = s1.mismatch_count;
  assign a_ff[0] = s0.first_fail;        assign a_ff[1] = s1.first_fail;
  assign a_tref[0] = s0.table_ref;       assign a_tref[1] = s1.table_ref;
  assign a_tdut[0] = s0.table_dut;       assign a_tdut[1] = s1.table_dut;

  // Reference model state: elapsed cycles since the accepted start edge.
  bit          m_act[2];
  int          m_k  [2];
  logic [3:0]  e_vec [2];
  logic        e_busy[2], e_done[2], e_rv[2], e_pass[2], e_ffv[2];
  logic [4:0]  e_cnt [2];
  logic [3:0]  e_ff  [2];
  logic [15:0] e_tref[2], e_tdut[2];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
  endtask

  function automatic int period(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic m_clear_results(input int i);
    e_rv[i] = 1'b0; e_pass[i] = 1'b0; e_cnt[i] = '0; e_ff[i] = '0;
    e_ffv[i] = 1'b0; e_tref[i] = '0; e_tdut[i] = '0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int p, len, v;
      p   = period(i);
      len = 16 * p;
      if (reset) begin
        m_clear_results(i);
        e_vec[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        m_act[i] = 1'b0; m_k[i] = 0;
      end else if (m_act[i]) begin
        if (abort) begin
          e_vec[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
          e_rv[i] = 1'b0; e_pass[i] = 1'b0; m_act[i] = 1'b0;
        end else begin
          m_k[i]++;
          if ((m_k[i] % p) == 0 && m_k[i] <= len) begin
            v = m_k[i] / p - 1;
            e_tref[i][v] = tt_ref[v];
            e_tdut[i][v] = tt_dut[v];
            if (tt_ref[v] != tt_dut[v]) begin
              e_cnt[i] = e_cnt[i] + 5'd1;
              if (!e_ffv[i]) begin
                e_ff[i] = 4'(v); e_ffv[i] = 1'b1;
              end
            end
          end
          if (m_k[i] < len) begin
            e_vec[i] = 4'(m_k[i] / p); e_busy[i] = 1'b1;
          end else if (m_k[i] == len) begin
            e_vec[i] = 4'd15; e_busy[i] = 1'b0; e_done[i] = 1'b1;
            e_rv[i] = 1'b1; e_pass[i] = (e_cnt[i] == 5'd0);
          end else begin
            e_vec[i] = '0; e_done[i] = 1'b0; m_act[i] = 1'b0;
          end
        end
      end else if (start && !abort) begin
        m_clear_results(i);
        e_vec[i] = '0; e_busy[i] = 1'b1; e_done[i] = 1'b0;
        m_act[i] = 1'b1; m_k[i] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every falling edge: compare both instances against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d.vec", i),  a_vec[i],  e_vec[i]);
        chk($sformatf("d%0d.busy", i), a_busy[i], e_busy[i]);
        chk($sformatf("d%0d.done", i), a_done[i], e_done[i]);
        chk($sformatf("d%0d.rv", i),   a_rv[i],   e_rv[i]);
        chk($sformatf("d%0d.pass", i), a_pass[i], e_pass[i]);
        chk($sformatf("d%0d.cnt", i),  a_cnt[i],  e_cnt[i]);
        chk($sformatf("d%0d.ff", i),   a_ff[i],   e_ff[i]);
        chk($sformatf("d%0d.ffv", i),  a_ffv[i],  e_ffv[i]);
        chk($sformatf("d%0d.tref", i), a_tref[i], e_tref[i]);
        chk($sformatf("d%0d.tdut", i), a_tdut[i], e_tdut[i]);
      end
    end
  end

  // Start one sweep, optionally pulse start while busy, and log done timing.
  task automatic run_sweep(input bit noise, input bit clr,
                           output int f0, output int f1, output int c0, output int c1);
    f0 = -1; f1 = -1; c0 = 0; c1 = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (clr) begin
      chk("clr.rv",   a_rv[1],   0);
      chk("clr.cnt",  a_cnt[1],  0);
      chk("clr.ffv",  a_ffv[1],  0);
      chk("clr.tref", a_tref[1], 0);
      chk("clr.tdut", a_tdut[1], 0);
    end
    for (int e = 0; e < 40; e++) begin
      if (a_done[0]) begin if (c0 == 0) f0 = e; c0++; end
      if (a_done[1]) begin if (c1 == 0) f1 = e; c1++; end
      @(negedge clk);
      start = noise && (e == 4 || e == 9);
    end
    start = 1'b0;
  endtask

  initial begin
    int f0, f1, c0, c1, seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    tt_ref = F_TT; tt_dut = F_TT;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst.vec",  a_vec[i],  0);
      chk("rst.busy", a_busy[i], 0);
      chk("rst.done", a_done[i], 0);
      chk("rst.cnt",  a_cnt[i],  0);
      chk("rst.tref", a_tref[i], 0);
    end
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    // Equivalent circuits.
    run_sweep(1'b0, 1'b0, f0, f1, c0, c1);
    chk("eq.done_at1", f1, 32);
    chk("eq.done_len1", c1, 1);
    chk("eq.done_at0", f0, 16);
    chk("eq.done_len0", c0, 1);
    chk("eq.tref", a_tref[1], 16'h8585);
    chk("eq.tdut", a_tdut[1], 16'h8585);
    chk("eq.cnt",  a_cnt[1], 0);
    chk("eq.pass", a_pass[1], 1);
    chk("eq.ffv",  a_ffv[1], 0);
    chk("eq.rv",   a_rv[1], 1);

    // Vector 7 inverted; previous results must be cleared at start.
    tt_dut = F_TT ^ 16'h0080;
    run_sweep(1'b0, 1'b1, f0, f1, c0, c1);
    chk("v7.cnt",  a_cnt[1], 1);
    chk("v7.ff",   a_ff[1], 7);
    chk("v7.ffv",  a_ffv[1], 1);
    chk("v7.pass", a_pass[1], 0);
    chk("v7.tdut", a_tdut[1], 16'h8505);

    // Inverted DUT, with start pulses while busy.
    tt_dut = ~F_TT;
    run_sweep(1'b1, 1'b1, f0, f1, c0, c1);
    chk("inv.cnt0",  a_cnt[0], 16);
    chk("inv.ff0",   a_ff[0], 0);
    chk("inv.tdut0", a_tdut[0], 16'h7A7A);
    chk("inv.done_at0", f0, 16);
    chk("inv.done_len0", c0, 1);
    chk("inv.done_at1", f1, 32);
    chk("inv.done_len1", c1, 1);
    chk("inv.cnt1",  a_cnt[1], 16);

    // Abort after vector 5 is sampled on the SETTLE=1 instance.
    tt_dut = F_TT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab.busy", a_busy[1], 0);
    chk("ab.rv",   a_rv[1], 0);
    chk("ab.vec",  a_vec[1], 0);
    chk("ab.pass", a_pass[1], 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_done[1]) seen++;
      @(negedge clk);
    end
    chk("ab.nodone", seen, 0);
    run_sweep(1'b0, 1'b0, f0, f1, c0, c1);
    chk("ab.resweep_pass1", a_pass[1], 1);
    chk("ab.resweep_rv1",   a_rv[1], 1);
    chk("ab.resweep_pass0", a_pass[0], 1);

    // Reset while vector 9 is on the bus, with start in the same cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("rs.vec9", a_vec[1], 9);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rs.vec",  a_vec[1], 0);
    chk("rs.busy", a_busy[1], 0);
    chk("rs.cnt",  a_cnt[1], 0);
    chk("rs.tref", a_tref[1], 0);
    chk("rs.tdut", a_tdut[1], 0);
    chk("rs.rv",   a_rv[1], 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rs.nostart1", a_busy[1], 0);
    chk("rs.nostart0", a_busy[0], 0);

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa.busy0", a_busy[0], 0);
    chk("sa.busy1", a_busy[1], 0);
    @(negedge clk);

    // Randomized commands and circuits, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        int r;
        tt_ref = 16'($urandom);
        r = $urandom_range(0, 2);
        if (r == 0)      tt_dut = tt_ref;
        else if (r == 1) tt_dut = tt_ref ^ (16'd1 << $urandom_range(0, 15));
        else             tt_dut = 16'($urandom);
      end
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 79) == 0);
      reset = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
